// File: rtl/gcd_controller.sv
// Sequencing FSM for a subtract-and-compare GCD datapath.
// Drives mux selects and load enables, and bounds the iteration count so zero operands end in an error.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; all control outputs low
// LOAD  | datapath captures in1/in2 into A/B
// CALC  | one subtract per cycle until A == B or the iteration cap
// DONE  | one-cycle done pulse; error qualifies an aborted run
module gcd_controller #(
  parameter int CW       = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          a_gt_b,
  input  logic          a_eq_b,
  input  logic          a_lt_b,
  output logic          a_sel,
  output logic          b_sel,
  output logic          a_ld,
  output logic          b_ld,
  output logic          output_en,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] iter_count
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ITER);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_q, err_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    err_nx    = err_q;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    output_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      LOAD: begin
        a_sel    = 1'b1;
        b_sel    = 1'b1;
        a_ld     = 1'b1;
        b_ld     = 1'b1;
        state_nx = CALC;
      end
      CALC: begin
        // Equality wins over the cap; no valid flag at all is treated as an abort.
        if (a_eq_b) begin
          output_en = 1'b1;
          err_nx    = 1'b0;
          state_nx  = DONE;
        end else if (cnt == MAX_CNT || !(a_gt_b || a_lt_b)) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else if (a_gt_b) begin
          a_ld   = 1'b1;
          cnt_nx = cnt + CW'(1);
        end else begin
          b_ld   = 1'b1;
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign error      = (state == DONE) && err_q;
  assign iter_count = cnt;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a small A/B datapath closes the loop, and a
// plain-arithmetic GCD model predicts result, iteration count, error and latency.
module tb_gcd_controller;

  localparam int CW   = 16;
  localparam int MAXI = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          a_gt_b, a_eq_b, a_lt_b;
  logic          a_sel, b_sel, a_ld, b_ld, output_en, busy, done, error;
  logic [CW-1:0] iter_count;

  logic [15:0] in1, in2, a_reg, b_reg, out_reg;
  logic        force_flags;
  logic [2:0]  rnd_flags;

  int tests  = 0;
  int failed = 0;
  int exp_out;

  gcd_controller #(.CW(CW), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
    .a_sel(a_sel), .b_sel(b_sel), .a_ld(a_ld), .b_ld(b_ld),
    .output_en(output_en), .busy(busy), .done(done), .error(error),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
    end else begin
      if (a_ld)      a_reg   <= a_sel ? in1 : a_reg - b_reg;
      if (b_ld)      b_reg   <= b_sel ? in2 : b_reg - a_reg;
      if (output_en) out_reg <= a_reg;
    end
  end

  always_comb begin
    a_gt_b = a_reg > b_reg;
    a_eq_b = a_reg == b_reg;
    a_lt_b = a_reg < b_reg;
    if (force_flags) {a_gt_b, a_eq_b, a_lt_b} = rnd_flags;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Euclid by repeated subtraction, capped at MAXI subtractions.
  task automatic ref_model(input int x, input int y, output int g, output int n, output logic e);
    int a, b;
    a = x; b = y; n = 0; g = 0; e = 1'b0;
    forever begin
      if (a == b) begin g = a; return; end
      if (n == MAXI) begin e = 1'b1; return; end
      if (a > b) a = a - b; else b = b - a;
      n++;
    end
  endtask

  // Entered at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
  // mode 0: single start pulse; 1: start held high; 2: random start noise while busy.
  task automatic run_op(input int x, input int y, input int mode);
    int g, n, cyc, subs, oe_cnt;
    logic e;
    bit seen;
    ref_model(x, y, g, n, e);
    in1 = 16'(x); in2 = 16'(y); start = 1'b1;
    check("idle_before_start", busy, 0);
    @(negedge clk); cyc = 1;
    if (mode == 0) start = 1'b0;
    else if (mode == 2) start = 1'($urandom_range(0, 1));
    check("load_ctrl", {a_sel, b_sel, a_ld, b_ld, output_en, busy, done}, 7'b1111010);
    subs = 0; oe_cnt = 0; seen = 0;
    while (!seen && cyc < MAXI + 10) begin
      @(negedge clk); cyc++;
      if (mode == 2) start = 1'($urandom_range(0, 1));
      if ((a_ld && !a_sel) || (b_ld && !b_sel)) subs++;
      if (output_en) oe_cnt++;
      if (done) seen = 1;
    end
    if (mode == 2) start = 1'b1;
    check("done_seen", 32'(seen), 1);
    check("latency", cyc, n + 3);
    check("error", error, 32'(e));
    check("iter_count", iter_count, n);
    check("subtractions", subs, n);
    check("out", out_reg, e ? exp_out : g);
    check("output_en_count", oe_cnt, e ? 0 : 1);
    if (!e) exp_out = g;
    @(negedge clk);
    if (mode != 1) start = 1'b0;
    check("post_idle", {busy, done, error, a_ld, b_ld, output_en}, 0);
    check("iter_hold", iter_count, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    force_flags = 1'b0; rnd_flags = '0; exp_out = 0;
    #1;
    check("reset_outputs", {a_sel, b_sel, a_ld, b_ld, output_en, busy, done, error}, 0);
    check("reset_iter", iter_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle with random flags: nothing may load.
    force_flags = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rnd_flags = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("idle_random_flags", {a_sel, b_sel, a_ld, b_ld, output_en, busy, done, error}, 0);
    end
    force_flags = 1'b0;
    @(negedge clk);

    run_op(48, 18, 0);
    run_op(7, 7, 0);
    run_op(5, 0, 0);
    run_op(0, 5, 2);
    run_op(0, 0, 0);

    // Back-to-back with start held: one IDLE cycle between runs.
    run_op(48, 18, 1);
    run_op(9, 6, 1);
    run_op(17, 1, 0);

    // Start noise during CALC/DONE must not cause extra runs.
    run_op(35, 21, 2);
    run_op(12, 30, 2);

    // Asynchronous reset in the middle of CALC.
    in1 = 16'd48; in2 = 16'd18; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midcalc_reset_outputs", {a_sel, b_sel, a_ld, b_ld, output_en, busy, done, error}, 0);
    check("midcalc_reset_iter", iter_count, 0);
    check("midcalc_reset_out", out_reg, 0);
    @(negedge clk); rst = 1'b0;
    exp_out = 0;
    @(negedge clk);
    run_op(48, 18, 0);

    for (int i = 0; i < 12; i++) begin
      run_op($urandom_range(0, 40), $urandom_range(0, 40), (i % 3 == 1) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
